// File: rtl/hit_collector.sv
// hit_collector: mole-button front end.
// Synchronizes and debounces the active-low buttons, turns debounced presses
// on lit moles into one-cycle hit pulses, and accumulates hits into a
// saturating pending increment. The register-file write port takes that
// increment in any cycle the processor is not using the port.
// Optional build macro HIT_COLLECTOR_MISS_COUNT_EN adds a saturating count of
// presses made while the LED was off. Without the macro, miss_count is tied to 0.
module hit_collector #(
  parameter int N_MOLE          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int PEND_W          = 8,
  parameter int SCORE_W         = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_MOLE-1:0]   btn_n,
  input  logic [N_MOLE-1:0]   led_on,
  input  logic                port_busy,
  output logic [N_MOLE-1:0]   btn_level,
  output logic [N_MOLE-1:0]   hit_pulse,
  output logic                add_valid,
  output logic [SCORE_W-1:0]  add_amount,
  output logic [15:0]         miss_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PEND_W:0]  PEND_MAX = {1'b0, {PEND_W{1'b1}}};

  logic [N_MOLE-1:0] sync1, sync2;
  logic [N_MOLE-1:0] stable, stable_d;
  logic [N_MOLE-1:0] press;
  logic [CNT_W-1:0]  cnt [N_MOLE];
  logic [PEND_W-1:0] pending;
  logic [PEND_W:0]   hit_cnt;
  logic [PEND_W:0]   pend_sum;
  logic              accept;

  function automatic logic [PEND_W:0] popcount(input logic [N_MOLE-1:0] v);
    logic [PEND_W:0] c;
    c = '0;
    for (int i = 0; i < N_MOLE; i++) c = c + (PEND_W+1)'(v[i]);
    return c;
  endfunction

  // Two-flop synchronizer; released (1) out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '1;
      for (int i = 0; i < N_MOLE; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_MOLE; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Delayed copy of the debounced level for falling-edge (press) detection.
  always_ff @(posedge clk) begin
    if (reset) stable_d <= '1;
    else       stable_d <= stable;
  end

  assign press     = stable_d & ~stable;
  assign btn_level = stable;

  // A press only counts as a hit while that mole is lit.
  always_ff @(posedge clk) begin
    if (reset) hit_pulse <= '0;
    else       hit_pulse <= press & led_on;
  end

  // Pending-increment arithmetic; hits landing in an accept cycle restart the total.
  always_comb begin
    hit_cnt  = popcount(hit_pulse);
    pend_sum = {1'b0, pending} + hit_cnt;
    accept   = add_valid && !port_busy;
  end

  // Saturating accumulator of hits awaiting the write port.
  always_ff @(posedge clk) begin
    if (reset)                 pending <= '0;
    else if (accept)           pending <= hit_cnt[PEND_W-1:0];
    else if (pend_sum > PEND_MAX) pending <= PEND_MAX[PEND_W-1:0];
    else                       pending <= pend_sum[PEND_W-1:0];
  end

  assign add_valid  = (pending != '0);
  assign add_amount = SCORE_W'(pending);

`ifdef HIT_COLLECTOR_MISS_COUNT_EN
  logic [15:0] miss_q;
  logic [16:0] miss_sum;

  assign miss_sum = {1'b0, miss_q} + 17'(popcount(press & ~led_on));

  // Saturating count of presses on unlit moles.
  always_ff @(posedge clk) begin
    if (reset)            miss_q <= '0;
    else if (miss_sum[16]) miss_q <= 16'hFFFF;
    else                  miss_q <= miss_sum[15:0];
  end

  assign miss_count = miss_q;
`else
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_hit_collector.sv
module tb_hit_collector;

  localparam int D   = 4;
  localparam int HSZ = 65536;
`ifdef HIT_COLLECTOR_MISS_COUNT_EN
  localparam int EXP_MISS = 2;
`else
  localparam int EXP_MISS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn_n, led_on;
  logic        port_busy;
  logic [3:0]  btn_level, hit_pulse;
  logic        add_valid;
  logic [31:0] add_amount;
  logic [15:0] miss_count;

  int n_vec = 0;
  int n_err = 0;

  hit_collector #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .led_on(led_on),
    .port_busy(port_busy), .btn_level(btn_level), .hit_pulse(hit_pulse),
    .add_valid(add_valid), .add_amount(add_amount), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: raw-sample history since reset; a button's level flips
  // once its last D synchronized samples all disagree with the current level.
  logic [3:0] rawh [HSZ];
  int         cyc;
  logic [3:0] m_stab, m_press, m_hit;
  int         m_pend, m_miss;

  function automatic logic synced(int i, int k);
    if (k < 0) return 1'b1;
    return rawh[k][i];
  endfunction

  initial begin
    cyc = 0; m_stab = '1; m_press = '0; m_hit = '0; m_pend = 0; m_miss = 0;
  end

  always @(posedge clk) begin : model
    int  h;
    logic all_diff;
    if (reset) begin
      cyc = 0; m_stab = '1; m_press = '0; m_hit = '0; m_pend = 0; m_miss = 0;
    end else begin
      h = $countones(m_hit);
      if (m_pend != 0 && !port_busy) m_pend = h;
      else m_pend = (m_pend + h > 255) ? 255 : m_pend + h;
`ifdef HIT_COLLECTOR_MISS_COUNT_EN
      m_miss = m_miss + $countones(m_press & ~led_on);
      if (m_miss > 65535) m_miss = 65535;
`endif
      m_hit   = m_press & led_on;
      m_press = '0;
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (synced(i, cyc - 2 - j) == m_stab[i]) all_diff = 1'b0;
        if (all_diff) begin
          if (m_stab[i]) m_press[i] = 1'b1;
          m_stab[i] = ~m_stab[i];
        end
      end
      if (cyc < HSZ) rawh[cyc] = btn_n;
      cyc++;
    end
    #1;
    check("btn_level",  32'(btn_level),  32'(m_stab));
    check("hit_pulse",  32'(hit_pulse),  32'(m_hit));
    check("add_valid",  32'(add_valid),  32'(m_pend != 0));
    check("add_amount", add_amount,      32'(m_pend));
    check("miss_count", 32'(miss_count), 32'(m_miss));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_hit(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (hit_pulse != 4'b0) begin
        lat = k;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL hit_timeout: no hit_pulse within 40 cycles, expected one at %0t", $time);
  endtask

  task automatic press_release(input logic [3:0] pat);
    btn_n = pat;
    cycles(8);
    btn_n = 4'hF;
    cycles(8);
  endtask

  initial begin
    int lat;
    reset = 1'b1; btn_n = 4'hF; led_on = 4'h0; port_busy = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(1);
    check("rst_btn_level", 32'(btn_level), 32'hF);
    check("rst_hit", 32'(hit_pulse), 32'h0);
    check("rst_add_valid", 32'(add_valid), 32'h0);
    check("rst_amount", add_amount, 32'h0);

    // Glitch shorter than the debounce window.
    btn_n = 4'b1110; cycles(3); btn_n = 4'hF; cycles(12);
    check("glitch_level", 32'(btn_level), 32'hF);
    check("glitch_valid", 32'(add_valid), 32'h0);

    // Single hold on a lit mole.
    led_on = 4'b0001; port_busy = 1'b0; btn_n = 4'b1110;
    wait_hit(lat);
    check("hold_latency", 32'(lat), 32'd7);
    check("hold_hit", 32'(hit_pulse), 32'h1);
    cycles(1);
    check("hold_valid", 32'(add_valid), 32'h1);
    check("hold_amount", add_amount, 32'h1);
    cycles(1);
    check("hold_drained", 32'(add_valid), 32'h0);
    cycles(11);
    btn_n = 4'hF; cycles(12);

    // Simultaneous hits held off by a busy port.
    led_on = 4'hF; port_busy = 1'b1; btn_n = 4'b0101;
    wait_hit(lat);
    check("dual_hit", 32'(hit_pulse), 32'hA);
    cycles(4);
    check("dual_amount", add_amount, 32'h2);
    port_busy = 1'b0; cycles(1);
    check("dual_drained", 32'(add_valid), 32'h0);
    port_busy = 1'b1;
    btn_n = 4'hF; cycles(12);

    // Saturation at 255.
    for (int n = 0; n < 70; n++) press_release(4'h0);
    check("sat_amount", add_amount, 32'd255);
    press_release(4'h0);
    check("sat_nowrap", add_amount, 32'd255);
    port_busy = 1'b0; cycles(2);
    check("sat_drained", 32'(add_valid), 32'h0);

    // Hit arriving in the accept cycle.
    port_busy = 1'b1; led_on = 4'b0111;
    press_release(4'b1000);
    check("acc_pend3", add_amount, 32'd3);
    led_on = 4'b0100; btn_n = 4'b1011;
    wait_hit(lat);
    check("acc_hit", 32'(hit_pulse), 32'h4);
    port_busy = 1'b0; cycles(1);
    check("acc_amount", add_amount, 32'd1);
    btn_n = 4'hF; cycles(12);

    // Presses on an unlit mole.
    reset = 1'b1; cycles(1); reset = 1'b0;
    led_on = 4'h0;
    press_release(4'b1011);
    press_release(4'b1011);
    check("miss_count", 32'(miss_count), 32'(EXP_MISS));

    // Reset in the middle of a pending total and a debounce count.
    port_busy = 1'b1; led_on = 4'hF;
    press_release(4'h0);
    press_release(4'b1110);
    check("mid_pend5", add_amount, 32'd5);
    btn_n = 4'b1110; cycles(3);
    reset = 1'b1; cycles(1);
    check("mid_level", 32'(btn_level), 32'hF);
    check("mid_hit", 32'(hit_pulse), 32'h0);
    check("mid_valid", 32'(add_valid), 32'h0);
    check("mid_amount", add_amount, 32'h0);
    check("mid_miss", 32'(miss_count), 32'h0);
    reset = 1'b0;
    wait_hit(lat);
    check("mid_restart_lat", 32'(lat), 32'd7);
    btn_n = 4'hF; port_busy = 1'b0; cycles(12);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) btn_n[i] = ~btn_n[i];
      if ($urandom_range(3) == 0) led_on = 4'($urandom);
      port_busy = ($urandom_range(2) == 0);
      reset = ($urandom_range(499) == 0);
      cycles(1);
    end
    reset = 1'b0;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
